ahb_mm_arbiter: RTL and testbench
=================================

# ahb_mm_arbiter

Parametrised N-master AHB arbiter and bus multiplexer. It replaces the testbench-level muxing between master and slave interface views. It owns grant generation, address-phase and data-phase master tracking, and fixed-length burst locking. It drives a single shared slave-side bus.

## Interface
Parameters:
- NUM_MASTERS, 4, number of masters (2..16)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (master 0 highest)
- DEFAULT_MASTER, 0, parking master when no requests

Ports:
- HCLK  in  1  clock; one clock; everything is on the rising edge
- HRESET  in  1  reset; asynchronous, active-low
- mHBUSREQ  in  NUM_MASTERS  per-master bus request
- mHGRANT  out  NUM_MASTERS  one-hot grant, registered
- mHTRANS  in  NUM_MASTERS x 2  per-master transfer type
- mHADDR  in  NUM_MASTERS x ADDR_W  per-master address
- mHWRITE  in  NUM_MASTERS  per-master write
- mHSIZE, mHBURST  in  NUM_MASTERS x 3 each  per-master size, burst
- mHWDATA  in  NUM_MASTERS x DATA_W  per-master write data
- mHREADY, mHRESP, mHRDATA  out  1/2/DATA_W  HREADY/HRESP/HRDATA broadcast to all masters
- HTRANS, HADDR, HWRITE, HSIZE, HBURST  out  2/ADDR_W/1/3/3  muxed address phase to slave
- HWDATA  out  DATA_W  muxed write data
- HREADY, HRESP, HRDATA  in  1/2/DATA_W  slave response
- HMASTER  out  4  address-phase owner index

## Operation
- **Registers:**
  - grant_q: one-hot grant.
  - amaster_q: address owner, drives HMASTER.
  - dmaster_q: data owner.
  - beats_left: 5 bits.
  - rr_last: last granted index.
- **Muxes:** address/control outputs select amaster_q; HWDATA selects dmaster_q. Slave response passes straight through. All muxes are combinational, with zero added latency.
- **Ownership:** on every edge with HREADY=1, amaster_q <= index(grant_q) and dmaster_q <= amaster_q. When HREADY=0 the owners hold.
- **Arbitration enable:** arb_en = HREADY && !lock. lock = (beats_left >= 3) || start_fixed. start_fixed = owner HTRANS==NONSEQ and HBURST in 2..7.
- **Winner selection when arb_en:**
  - If no mHBUSREQ is set, park on DEFAULT_MASTER.
  - Fixed mode: the lowest requesting index wins.
  - RR mode: search from rr_last+1 with wrap; the first requester wins. The current owner keeps the bus only if no other master requests.
  - rr_last updates only when the grant moves to a different master.
- **Burst counter:**
  - On an HREADY=1 edge with owner NONSEQ: load beats_left with len-1. len is 4 for HBURST 2/3, 8 for 4/5, 16 for 6/7. SINGLE and INCR (HBURST 0/1) load 0.
  - On an HREADY=1 edge with owner SEQ and beats_left>0: decrement.
  - BUSY: hold.
  - Owner IDLE on an HREADY=1 edge (early termination): clear to 0.
- **Unlocked traffic:** INCR and SINGLE transfers are never locked, so re-arbitration can occur on any HREADY edge.
- **HRESP:** passed through only. Non-OKAY responses do not affect arbitration, because SPLIT/RETRY are not supported.

## Timing
- **Reset values:**
  - mHGRANT = one-hot DEFAULT_MASTER.
  - HMASTER = DEFAULT_MASTER; dmaster_q = DEFAULT_MASTER.
  - beats_left = 0; rr_last = DEFAULT_MASTER.
  - Slave outputs reflect the DEFAULT_MASTER inputs.
- **Request to grant:** 1 edge when arb_en. Grant to HMASTER change: the next HREADY=1 edge. HMASTER to HWDATA switch: the next HREADY=1 edge.
- **Fixed burst of length L:**
  - Grant may move at the edge accepting beat L-1 (beats_left=2).
  - HMASTER moves at the edge accepting beat L, so the next owner's NONSEQ immediately follows the last beat, with no idle cycle.
- **Wait states:** with HREADY=0, grant, owners and counter all freeze, even if requests change.
- **Same-edge request drop:** if the owner drops its request on the same edge as unlock, arbitration proceeds normally.
- **Reset mid-burst:** immediate return to reset values; no beat bookkeeping survives.

## Structure
- **Package ahb_pkg:**
  - htrans_t enum: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
  - hburst_t enum: SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16.
  - Function burst_len(hburst_t).
  - Constant MAX_MASTERS=16.
- **Sub-module ahb_arb_pick:** combinational priority/round-robin picker (req, rr_last, mode -> one-hot winner). Keep it separate for unit test.

## Test plan
- **Reset parking:** reset with no requests -> mHGRANT=0001 and HMASTER=0; the outputs mirror master 0.
- **RR rotation:** RR_MODE=1, masters 1 and 2 request continuously, SINGLE NONSEQ, HREADY=1 -> HMASTER sequence 1,2,1,2. The write data of each transfer appears on HWDATA one cycle after its address.
- **Fixed priority:** RR_MODE=0, masters 3 and 1 request -> master 1 granted. Master 3 is granted only after master 1 drops mHBUSREQ.
- **INCR8 lock:** master 0 issues INCR8 at 0x100 while master 2 requests -> HMASTER stays 0 for 8 accepted beats. Master 2's NONSEQ is on HADDR in the cycle after beat 8, with no gap.
- **Wait states and early termination:** HREADY=0 for 3 cycles during beat 3 of a WRAP4 -> grant, HMASTER and beats_left frozen. Owner IDLE after beat 2 -> beats_left=0 and re-arbitration on the next edge.
- **Async reset mid-burst:** HRESET low mid-INCR16 -> grant returns to DEFAULT_MASTER immediately, without a clock edge.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB transfer/burst encodings and helpers for the multi-master arbiter
package ahb_pkg;

  localparam int MAX_MASTERS = 16;

  typedef enum logic [1:0] {IDLE, BUSY, NONSEQ, SEQ} htrans_t;

  typedef enum logic [2:0] {SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16} hburst_t;

  // Beats in a fixed-length burst; SINGLE and INCR count as one so the counter loads zero
  function automatic logic [4:0] burst_len(hburst_t b);
    return (b == WRAP4 || b == INCR4) ? 5'd4 :
           (b == WRAP8 || b == INCR8) ? 5'd8 :
           (b == WRAP16 || b == INCR16) ? 5'd16 : 5'd1;
  endfunction

  function automatic logic [3:0] oh2idx(logic [MAX_MASTERS-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_MASTERS; i++)
      if (oh[i]) idx = 4'(i);
    return idx;
  endfunction

endpackage

// File: rtl/ahb_arb_pick.sv
// ahb_arb_pick: combinational one-hot winner, fixed priority or round-robin after rr_last
module ahb_arb_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [3:0]   rr_last,
  input  logic         rr_mode,
  output logic [N-1:0] win
);

  logic [4:0]     sh;
  logic [N-1:0]   rot;
  logic [N-1:0]   oh_r;
  logic [2*N-1:0] up;

  // Rotate so the search start sits at bit 0, take the lowest set bit, rotate back
  always_comb begin
    sh = rr_mode ? {1'b0, rr_last} + 5'd1 : 5'd0;
    rot = N'({req, req} >> sh);
    oh_r = rot & -rot;
    up = {{N{1'b0}}, oh_r} << sh;
    win = up[N-1:0] | up[2*N-1:N];
  end

endmodule

// File: rtl/ahb_mm_arbiter.sv
// ahb_mm_arbiter: N-master AHB arbiter with address/data-phase muxing and fixed-burst locking
module ahb_mm_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int RR_MODE        = 1,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                                HCLK,
  input  logic                                HRESET,
  input  logic [NUM_MASTERS-1:0]              mHBUSREQ,
  output logic [NUM_MASTERS-1:0]              mHGRANT,
  input  logic [NUM_MASTERS-1:0][1:0]         mHTRANS,
  input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]  mHADDR,
  input  logic [NUM_MASTERS-1:0]              mHWRITE,
  input  logic [NUM_MASTERS-1:0][2:0]         mHSIZE,
  input  logic [NUM_MASTERS-1:0][2:0]         mHBURST,
  input  logic [NUM_MASTERS-1:0][DATA_W-1:0]  mHWDATA,
  output logic                                mHREADY,
  output logic [1:0]                          mHRESP,
  output logic [DATA_W-1:0]                   mHRDATA,
  output logic [1:0]                          HTRANS,
  output logic [ADDR_W-1:0]                   HADDR,
  output logic                                HWRITE,
  output logic [2:0]                          HSIZE,
  output logic [2:0]                          HBURST,
  output logic [DATA_W-1:0]                   HWDATA,
  input  logic                                HREADY,
  input  logic [1:0]                          HRESP,
  input  logic [DATA_W-1:0]                   HRDATA,
  output logic [3:0]                          HMASTER
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [NUM_MASTERS-1:0] DEF_OH = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;

  logic [NUM_MASTERS-1:0] grant_q, grant_d, win, pick;
  logic [3:0]             amaster_q, amaster_d, dmaster_q, dmaster_d, rr_last_q, rr_last_d;
  logic [4:0]             beats_left_q, beats_left_d;
  logic [IW-1:0]          a_sel, d_sel;
  logic                   start_fixed, lock, arb_en;

  ahb_arb_pick #(.N(NUM_MASTERS)) u_pick (
    .req    (mHBUSREQ),
    .rr_last(rr_last_q),
    .rr_mode(RR_MODE != 0),
    .win    (win)
  );

  assign a_sel   = IW'(amaster_q);
  assign d_sel   = IW'(dmaster_q);
  assign HTRANS  = mHTRANS[a_sel];
  assign HADDR   = mHADDR[a_sel];
  assign HWRITE  = mHWRITE[a_sel];
  assign HSIZE   = mHSIZE[a_sel];
  assign HBURST  = mHBURST[a_sel];
  assign HWDATA  = mHWDATA[d_sel];
  assign mHREADY = HREADY;
  assign mHRESP  = HRESP;
  assign mHRDATA = HRDATA;
  assign mHGRANT = grant_q;
  assign HMASTER = amaster_q;

  // Next grant, ownership pipeline and burst bookkeeping; everything holds while HREADY is low
  always_comb begin
    pick = |mHBUSREQ ? win : DEF_OH;
    start_fixed = HTRANS == NONSEQ && HBURST >= 3'd2;
    lock = beats_left_q >= 5'd3 || start_fixed;
    arb_en = HREADY && !lock;
    grant_d = arb_en ? pick : grant_q;
    rr_last_d = (arb_en && pick != grant_q) ? oh2idx(MAX_MASTERS'(pick)) : rr_last_q;
    amaster_d = HREADY ? oh2idx(MAX_MASTERS'(grant_q)) : amaster_q;
    dmaster_d = HREADY ? amaster_q : dmaster_q;
    beats_left_d = !HREADY ? beats_left_q :
                   HTRANS == NONSEQ ? burst_len(hburst_t'(HBURST)) - 5'd1 :
                   (HTRANS == SEQ && beats_left_q != 5'd0) ? beats_left_q - 5'd1 :
                   HTRANS == IDLE ? 5'd0 : beats_left_q;
  end

  // State registers, cleared to the parking master on reset
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      grant_q      <= DEF_OH;
      amaster_q    <= 4'(DEFAULT_MASTER);
      dmaster_q    <= 4'(DEFAULT_MASTER);
      rr_last_q    <= 4'(DEFAULT_MASTER);
      beats_left_q <= '0;
    end else begin
      grant_q      <= grant_d;
      amaster_q    <= amaster_d;
      dmaster_q    <= dmaster_d;
      rr_last_q    <= rr_last_d;
      beats_left_q <= beats_left_d;
    end
  end

endmodule

// File: tb/tb_ahb_mm_arbiter.sv
// tb_ahb_mm_arbiter: random and directed checks of RR and fixed-priority arbiters against a reference model
module tb_ahb_mm_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LEN [8] = '{1, 1, 4, 4, 8, 8, 16, 16};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]         req;
  logic [N-1:0][1:0]    trans;
  logic [N-1:0][AW-1:0] addr;
  logic [N-1:0]         wr;
  logic [N-1:0][2:0]    size;
  logic [N-1:0][2:0]    burst;
  logic [N-1:0][DW-1:0] wdata;
  logic                 hready;
  logic [1:0]           hresp;
  logic [DW-1:0]        hrdata;

  logic [N-1:0]  gnt      [2];
  logic [1:0]    o_trans  [2];
  logic [AW-1:0] o_addr   [2];
  logic          o_wr     [2];
  logic [2:0]    o_size   [2];
  logic [2:0]    o_burst  [2];
  logic [DW-1:0] o_wdata  [2];
  logic [3:0]    o_master [2];
  logic          m_ready  [2];
  logic [1:0]    m_resp   [2];
  logic [DW-1:0] m_rdata  [2];

  // index 0 runs round-robin, index 1 fixed priority
  for (genvar g = 0; g < 2; g++) begin : g_dut
    ahb_mm_arbiter #(
      .NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(g == 0 ? 1 : 0), .DEFAULT_MASTER(0)
    ) u_dut (
      .HCLK(clk), .HRESET(rst_n), .mHBUSREQ(req), .mHGRANT(gnt[g]),
      .mHTRANS(trans), .mHADDR(addr), .mHWRITE(wr), .mHSIZE(size), .mHBURST(burst),
      .mHWDATA(wdata), .mHREADY(m_ready[g]), .mHRESP(m_resp[g]), .mHRDATA(m_rdata[g]),
      .HTRANS(o_trans[g]), .HADDR(o_addr[g]), .HWRITE(o_wr[g]), .HSIZE(o_size[g]),
      .HBURST(o_burst[g]), .HWDATA(o_wdata[g]), .HREADY(hready), .HRESP(hresp),
      .HRDATA(hrdata), .HMASTER(o_master[g])
    );
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: grant holder, address owner, data owner, last RR winner, beats still owed by a fixed burst
  int m_gnt [2], m_aown [2], m_down [2], m_rr [2], m_rem [2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_gnt[m] = 0; m_aown[m] = 0; m_down[m] = 0; m_rr[m] = 0; m_rem[m] = 0;
    end
  endtask

  function automatic int pick(int m);
    if (req == '0) return 0;
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m == 1) ? k - 1 : (m_rr[m] + k) % N;
      if (req[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      int t, b, ng;
      bit locked;
      t = int'(trans[m_aown[m]]);
      b = int'(burst[m_aown[m]]);
      ng = m_gnt[m];
      locked = (t == 2 && b >= 2) || m_rem[m] >= 3;
      if (hready) begin
        if (!locked) begin
          ng = pick(m);
          if (ng != m_gnt[m]) m_rr[m] = ng;
        end
        m_down[m] = m_aown[m];
        m_aown[m] = m_gnt[m];
        m_gnt[m] = ng;
        if (t == 2) m_rem[m] = LEN[b] - 1;
        else if (t == 3 && m_rem[m] > 0) m_rem[m]--;
        else if (t == 0) m_rem[m] = 0;
      end
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 2; m++) begin
      check($sformatf("grant%0d", m), gnt[m], 64'(1) << m_gnt[m]);
      check($sformatf("hmaster%0d", m), o_master[m], m_aown[m]);
      check($sformatf("haddr%0d", m), o_addr[m], addr[m_aown[m]]);
      check($sformatf("htrans%0d", m), o_trans[m], trans[m_aown[m]]);
      check($sformatf("hburst%0d", m), o_burst[m], burst[m_aown[m]]);
      check($sformatf("hwrite%0d", m), o_wr[m], wr[m_aown[m]]);
      check($sformatf("hsize%0d", m), o_size[m], size[m_aown[m]]);
      check($sformatf("hwdata%0d", m), o_wdata[m], wdata[m_down[m]]);
      check($sformatf("mready%0d", m), m_ready[m], hready);
      check($sformatf("mresp%0d", m), m_resp[m], hresp);
      check($sformatf("mrdata%0d", m), m_rdata[m], hrdata);
    end
  endtask

  task automatic idle_inputs();
    req = '0; hready = 1'b1; hresp = 2'd0; hrdata = 32'hCAFE_0000;
    for (int i = 0; i < N; i++) begin
      trans[i] = 2'd0; burst[i] = 3'd0; size[i] = 3'd2; wr[i] = i[0];
      addr[i] = 32'h1000 * (i + 1); wdata[i] = 32'hD000_0000 + i;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    model_reset();
    check_all();
    rst_n = 1'b1;
  endtask

  // one clock: model and DUT advance on the edge, outputs compared just after, inputs change at negedge
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);
    // reset parking on master 0
    do_reset();
    check("rst_grant", gnt[0], 4'b0001);
    check("rst_hmaster", o_master[0], 0);
    check("rst_haddr", o_addr[0], 32'h1000);
    // round-robin between masters 1 and 2 with SINGLE transfers
    do_reset();
    req = 4'b0110;
    for (int i = 0; i < N; i++) trans[i] = 2'd2;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k >= 2) check("rr_hmaster", o_master[0], (k % 2 == 0) ? 1 : 2);
      if (k >= 3) check("rr_hwdata", o_wdata[0], wdata[(k % 2 == 0) ? 2 : 1]);
    end
    // fixed priority between masters 3 and 1
    do_reset();
    req = 4'b1010;
    step();
    check("fx_grant1", gnt[1], 4'b0010);
    step();
    check("fx_grant1_hold", gnt[1], 4'b0010);
    req = 4'b1000;
    step();
    check("fx_grant3", gnt[1], 4'b1000);
    // INCR8 by master 0 locks out master 2 until the last beat
    do_reset();
    req = 4'b0100;
    trans[2] = 2'd2; addr[2] = 32'h200;
    for (int k = 1; k <= 8; k++) begin
      trans[0] = (k == 1) ? 2'd2 : 2'd3; burst[0] = 3'd5; addr[0] = 32'h100 + 4 * (k - 1);
      step();
      for (int m = 0; m < 2; m++) begin
        if (k < 8) check("incr8_hmaster", o_master[m], 0);
        if (k == 6) check("incr8_grant_locked", gnt[m], 4'b0001);
        if (k == 7) check("incr8_grant_moved", gnt[m], 4'b0100);
        if (k == 8) check("incr8_next_owner", o_master[m], 2);
        if (k == 8) check("incr8_next_haddr", o_addr[m], 32'h200);
      end
    end
    // wait states inside a WRAP4 freeze everything
    do_reset();
    req = 4'b0010;
    burst[0] = 3'd2;
    trans[0] = 2'd2; step();
    trans[0] = 2'd3; step();
    hready = 1'b0; req = 4'b1010;
    repeat (3) begin
      step();
      check("wait_grant", gnt[0], 4'b0001);
      check("wait_hmaster", o_master[0], 0);
      check("wait_beats_rr", g_dut[0].u_dut.beats_left_q, 2);
      check("wait_beats_fx", g_dut[1].u_dut.beats_left_q, 2);
    end
    hready = 1'b1;
    step();
    check("wait_release_rr", gnt[0], 4'b0010);
    check("wait_release_fx", gnt[1], 4'b0010);
    // early termination of an INCR8 by going IDLE
    do_reset();
    req = 4'b0010;
    burst[0] = 3'd5;
    trans[0] = 2'd2; step();
    trans[0] = 2'd3; step();
    trans[0] = 2'd0; step();
    check("early_beats", g_dut[0].u_dut.beats_left_q, 0);
    check("early_grant_hold", gnt[0], 4'b0001);
    step();
    check("early_rearb", gnt[0], 4'b0010);
    // asynchronous reset in the middle of an INCR16 owned by master 1
    do_reset();
    req = 4'b0010;
    step(); step();
    req = 4'b0110; trans[1] = 2'd2; burst[1] = 3'd7;
    step();
    trans[1] = 2'd3;
    repeat (3) step();
    check("ar_pre_grant", gnt[0], 4'b0010);
    check("ar_pre_hmaster", o_master[0], 1);
    #2 rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      check("ar_grant", gnt[m], 4'b0001);
      check("ar_hmaster", o_master[m], 0);
      check("ar_haddr", o_addr[m], addr[0]);
    end
    check("ar_beats", g_dut[0].u_dut.beats_left_q, 0);
    @(negedge clk);
    do_reset();
    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      req = N'($urandom);
      hready = $urandom_range(0, 3) != 0;
      hresp = 2'($urandom);
      hrdata = $urandom;
      for (int i = 0; i < N; i++) begin
        int r;
        r = $urandom_range(0, 9);
        trans[i] = (r < 2) ? 2'd0 : (r < 3) ? 2'd1 : (r < 6) ? 2'd2 : 2'd3;
        burst[i] = 3'($urandom_range(0, 7));
        size[i] = 3'($urandom_range(0, 2));
        wr[i] = 1'($urandom);
        addr[i] = $urandom;
        wdata[i] = $urandom;
      end
      if ($urandom_range(0, 299) == 0) do_reset();
      else step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
